// File: rtl/botoes_debounce_if.sv
// Button bus between the raw switch inputs and the debounce stage.
//   botoes_brutos : raw, asynchronous button levels (1 = pressed)
//   botoes        : debounced per-button level
//   pressionado   : one-cycle pulse per button on an accepted press
//   soltou        : one-cycle pulse per button on an accepted release
//   algum         : at least one debounced button is held
//   multiplo      : two or more debounced buttons are held
// The master modport is the side that drives the raw levels; slave is the debouncer.
interface botoes_debounce_if;
  logic [7:0] botoes_brutos;
  logic [7:0] botoes;
  logic [7:0] pressionado;
  logic [7:0] soltou;
  logic       algum;
  logic       multiplo;

  modport master (
    output botoes_brutos,
    input  botoes,
    input  pressionado,
    input  soltou,
    input  algum,
    input  multiplo
  );

  modport slave (
    input  botoes_brutos,
    output botoes,
    output pressionado,
    output soltou,
    output algum,
    output multiplo
  );
endinterface

// File: rtl/botoes_debounce.sv
// Debounce and synchronisation for the eight puzzle push-buttons.
// Each raw level goes through a two-flop synchroniser, then a per-button FSM that accepts a
// change only after N_DEBOUNCE consecutive cycles of the new synchronised level.
//   clock : system clock, rising edge
//   reset : asynchronous, active-high, clears all state
//   bus   : botoes_debounce_if.slave (raw inputs in; levels, pulses and flags out)
// Parameters: N_DEBOUNCE in 2..2^W-1 stable cycles; W is the per-button counter width.
module botoes_debounce #(
  parameter int unsigned N_DEBOUNCE = 10,
  parameter int unsigned W          = 4
) (
  input logic              clock,
  input logic              reset,
  botoes_debounce_if.slave bus
);

  typedef enum logic [1:0] {
    StSolto,
    StConfPress,
    StPressionado,
    StConfSolta
  } state_e;

  localparam logic [W-1:0] CntOne  = W'(1);
  localparam logic [W-1:0] CntLast = W'(N_DEBOUNCE - 1);

  logic [7:0]   s1_q, s2_q;
  logic [7:0]   botoes_q, botoes_d;
  logic [7:0]   press_q, press_d;
  logic [7:0]   solt_q, solt_d;
  logic         algum_q, algum_d;
  logic         mult_q, mult_d;
  state_e       state_q [8];
  state_e       state_d [8];
  logic [W-1:0] cnt_q   [8];
  logic [W-1:0] cnt_d   [8];

  always_comb begin
    botoes_d = botoes_q;
    press_d  = '0;
    solt_d   = '0;
    for (int i = 0; i < 8; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        StSolto: begin
          if (s2_q[i]) begin
            state_d[i] = StConfPress;
            cnt_d[i]   = CntOne;
          end
        end
        StConfPress: begin
          if (!s2_q[i]) begin
            state_d[i] = StSolto;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i]  = StPressionado;
            botoes_d[i] = 1'b1;
            press_d[i]  = 1'b1;
            cnt_d[i]    = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        StPressionado: begin
          if (!s2_q[i]) begin
            state_d[i] = StConfSolta;
            cnt_d[i]   = CntOne;
          end
        end
        StConfSolta: begin
          if (s2_q[i]) begin
            state_d[i] = StPressionado;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i]  = StSolto;
            botoes_d[i] = 1'b0;
            solt_d[i]   = 1'b1;
            cnt_d[i]    = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        default: begin
          state_d[i] = StSolto;
          cnt_d[i]   = '0;
        end
      endcase
    end
    algum_d = |botoes_d;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    mult_d  = |(botoes_d & (botoes_d - 8'd1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      botoes_q <= '0;
      press_q  <= '0;
      solt_q   <= '0;
      algum_q  <= 1'b0;
      mult_q   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        state_q[i] <= StSolto;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q     <= bus.botoes_brutos;
      s2_q     <= s1_q;
      botoes_q <= botoes_d;
      press_q  <= press_d;
      solt_q   <= solt_d;
      algum_q  <= algum_d;
      mult_q   <= mult_d;
      for (int i = 0; i < 8; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign bus.botoes      = botoes_q;
  assign bus.pressionado = press_q;
  assign bus.soltou      = solt_q;
  assign bus.algum       = algum_q;
  assign bus.multiplo    = mult_q;

endmodule

// File: tb/tb_botoes_debounce.sv
// Bench for botoes_debounce: a run-length model of the debounce rule checked every cycle,
// directed scenarios with literal expectations, then randomised button activity.
module tb_botoes_debounce;
  localparam int unsigned N = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;

  botoes_debounce_if bus ();

  botoes_debounce #(
    .N_DEBOUNCE(N),
    .W         (4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
    end
  endfunction

  // Model: raw level seen by the decision logic is the raw sample from two edges back.
  // A button flips once that delayed level has disagreed with the accepted level for
  // N consecutive edges.
  logic [7:0] h1, h2;
  logic [7:0] m_bot, m_press, m_rel;
  logic       m_algum, m_mult;
  int         run [8];

  function automatic void model_clear();
    h1 = '0; h2 = '0; m_bot = '0; m_press = '0; m_rel = '0;
    m_algum = 1'b0; m_mult = 1'b0;
    for (int i = 0; i < 8; i++) run[i] = 0;
  endfunction

  function automatic void model_step(logic [7:0] raw);
    logic [7:0] seen;
    seen = h2;
    h2 = h1;
    h1 = raw;
    m_press = '0;
    m_rel = '0;
    for (int i = 0; i < 8; i++) begin
      if (seen[i] != m_bot[i]) begin
        run[i]++;
        if (run[i] == N) begin
          m_bot[i] = seen[i];
          if (seen[i]) m_press[i] = 1'b1;
          else m_rel[i] = 1'b1;
          run[i] = 0;
        end
      end else begin
        run[i] = 0;
      end
    end
    m_algum = (m_bot != 0);
    m_mult = ($countones(m_bot) >= 2);
  endfunction

  initial begin
    model_clear();
    forever begin
      @(posedge clock or posedge reset);
      #1;
      if (reset) model_clear();
      else model_step(bus.botoes_brutos);
      check("botoes", bus.botoes, m_bot);
      check("pressionado", bus.pressionado, m_press);
      check("soltou", bus.soltou, m_rel);
      check("algum", {7'd0, bus.algum}, {7'd0, m_algum});
      check("multiplo", {7'd0, bus.multiplo}, {7'd0, m_mult});
    end
  end

  // Ends 2 time units after a rising edge, after the per-cycle compare has run.
  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  logic [7:0] acc;
  logic [7:0] r;

  initial begin
    bus.botoes_brutos = '0;
    tick(3);
    reset = 1'b0;
    tick(3);

    // Reset asserted mid-cycle with all buttons held.
    #1;
    reset = 1'b1;
    bus.botoes_brutos = 8'hFF;
    #1;
    check("rst_botoes", bus.botoes, 8'h00);
    check("rst_flags", {6'd0, bus.algum, bus.multiplo}, 8'h00);
    tick(2);
    reset = 1'b0;
    tick(11);
    check("hold_ff_e11", bus.botoes, 8'h00);
    tick(1);
    check("hold_ff_botoes", bus.botoes, 8'hFF);
    check("hold_ff_press", bus.pressionado, 8'hFF);
    check("hold_ff_mult", {7'd0, bus.multiplo}, 8'h01);
    check("model_ff", m_bot, 8'hFF);
    tick(1);
    check("hold_ff_press_end", bus.pressionado, 8'h00);
    bus.botoes_brutos = 8'h00;
    tick(12);
    check("all_release", bus.soltou, 8'hFF);
    tick(3);

    // Clean press and release of bit 3.
    bus.botoes_brutos = 8'h08;
    tick(11);
    check("b3_e11", bus.botoes, 8'h00);
    tick(1);
    check("b3_botoes", bus.botoes, 8'h08);
    check("b3_press", bus.pressionado, 8'h08);
    check("b3_algum", {7'd0, bus.algum}, 8'h01);
    check("model_b3", m_press, 8'h08);
    tick(2);
    bus.botoes_brutos = 8'h00;
    tick(11);
    check("b3_rel_e11", bus.soltou, 8'h00);
    tick(1);
    check("b3_soltou", bus.soltou, 8'h08);
    check("b3_botoes_0", bus.botoes, 8'h00);
    tick(3);

    // Bounce on bit 0: high runs of 9 broken by single-cycle lows.
    acc = '0;
    for (int k = 0; k < 3; k++) begin
      bus.botoes_brutos = 8'h01;
      for (int c = 0; c < 9; c++) begin tick(1); acc |= bus.pressionado; end
      bus.botoes_brutos = 8'h00;
      tick(1);
      acc |= bus.pressionado;
    end
    bus.botoes_brutos = 8'h01;
    for (int c = 0; c < 11; c++) begin tick(1); acc |= bus.pressionado; end
    check("bounce_no_press", acc, 8'h00);
    tick(1);
    check("bounce_press", bus.pressionado, 8'h01);
    bus.botoes_brutos = 8'h00;
    tick(14);

    // Bits 1 and 6 together, then release bit 6 only.
    bus.botoes_brutos = 8'h42;
    tick(11);
    check("pair_mult_e11", {7'd0, bus.multiplo}, 8'h00);
    tick(1);
    check("pair_press", bus.pressionado, 8'h42);
    check("pair_mult", {7'd0, bus.multiplo}, 8'h01);
    tick(2);
    bus.botoes_brutos = 8'h02;
    tick(12);
    check("pair_soltou", bus.soltou, 8'h40);
    check("pair_mult_fall", {7'd0, bus.multiplo}, 8'h00);
    check("pair_algum", {7'd0, bus.algum}, 8'h01);
    bus.botoes_brutos = 8'h00;
    tick(14);

    // Reset while bit 5 is still being confirmed.
    acc = '0;
    bus.botoes_brutos = 8'h20;
    for (int c = 0; c < 8; c++) begin tick(1); acc |= bus.pressionado; end
    reset = 1'b1;
    tick(2);
    acc |= bus.pressionado;
    reset = 1'b0;
    for (int c = 0; c < 11; c++) begin tick(1); acc |= bus.pressionado; end
    check("rstconf_no_press", acc, 8'h00);
    tick(1);
    check("rstconf_press", bus.pressionado, 8'h20);
    bus.botoes_brutos = 8'h00;
    tick(14);

    // Single-cycle glitch on bit 2.
    acc = '0;
    bus.botoes_brutos = 8'h04;
    tick(1);
    bus.botoes_brutos = 8'h00;
    for (int c = 0; c < 15; c++) begin
      tick(1);
      acc |= bus.botoes | bus.pressionado | bus.soltou | {6'd0, bus.algum, bus.multiplo};
    end
    check("glitch_quiet", acc, 8'h00);

    // Random activity with mean hold time near the debounce length.
    r = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(11) == 0) r[i] = ~r[i];
      end
      bus.botoes_brutos = r;
      if (c % 500 == 250) begin
        #1;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end else begin
        tick(1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/botoes_debounce.md
# botoes_debounce

Debounce and synchronisation stage for the eight raw push-buttons of the LED-matrix puzzle. It sits directly upstream of the datapath's `botoes[7:0]` input and its edge detectors. It turns bouncing, asynchronous switch levels into clean, clock-aligned levels, plus one-cycle press and release pulses. It also flags when more than one button is held at once.

## Interface

Parameters:
- `N_DEBOUNCE`, default 10: consecutive stable cycles required to accept a change; legal range 2..(2^`W`−1). At the 1 kHz system clock this is 10 ms.
- `W`, default 4: width of each per-button stability counter; must satisfy 2^`W` > `N_DEBOUNCE`.

Ports:
- `clock` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `botoes_brutos` in 8: raw button levels, 1 = pressed; asynchronous to `clock`.
- `botoes` out 8: debounced level per button, registered.
- `pressionado` out 8: one-cycle pulse per button on accepted press.
- `soltou` out 8: one-cycle pulse per button on accepted release.
- `algum` out 1: OR of `botoes`, registered.
- `multiplo` out 1: high while two or more bits of `botoes` are 1, registered.

## Operation

- **Synchronisation.** Each bit passes a two-flop synchroniser `s1 → s2`. Only `s2` feeds the per-button state machines.
- **Per-button FSM.** There are eight independent instances, each with a `W`-bit counter `cnt`. States:
  - SOLTO: `botoes[i]`=0. If `s2`=1, go to CONF_PRESS with `cnt`=1; otherwise stay.
  - CONF_PRESS:
    - If `s2`=0, return to SOLTO with `cnt`=0.
    - Else if `cnt`==`N_DEBOUNCE`−1, go to PRESSIONADO: set `botoes[i]`=1, assert `pressionado[i]`, clear `cnt`.
    - Else `cnt`+1.
  - PRESSIONADO: `botoes[i]`=1. If `s2`=0, go to CONF_SOLTA with `cnt`=1.
  - CONF_SOLTA:
    - If `s2`=1, return to PRESSIONADO with `cnt`=0.
    - Else if `cnt`==`N_DEBOUNCE`−1, go to SOLTO: set `botoes[i]`=0, assert `soltou[i]`, clear `cnt`.
    - Else `cnt`+1.
- **Counter behaviour.** `cnt` never exceeds `N_DEBOUNCE`−1, so no wrap-around is possible.
- **Pulses.** `pressionado` and `soltou` are registered. Each is high for exactly the one cycle in which the corresponding `botoes` bit has just changed, and low in all other cycles.
- **Aggregate flags.** `algum` and `multiplo` are computed from the next-state value of `botoes` and registered, so they change in the same cycle as `botoes`. `multiplo` uses a population count ≥ 2.
- **Independence of buttons.** Simultaneous events on different buttons are handled independently. Several `pressionado` bits may be high in the same cycle.

## Timing

- **Reset values.** While `reset`=1, and immediately on its assertion: `s1`, `s2`, `botoes`, `pressionado`, `soltou`, `algum`, `multiplo` and every `cnt` are 0, and every FSM is in SOLTO.
- **Latency.** Raw level changes and then holds stable with setup before edge 1:
  - `s2` takes the new value at edge 2.
  - The FSM enters CONF_* at edge 3.
  - `botoes[i]`, the pulse, `algum` and `multiplo` update at edge 2+`N_DEBOUNCE` (edge 12 for the default).
- **Glitch rejection.** Any raw glitch whose synchronised image lasts fewer than `N_DEBOUNCE` cycles leaves `botoes` and the pulses untouched. The counter restarts from 1 on the next change.
- **Reset mid-operation.** Partial counts are discarded and no pulse is emitted.
  - If a button is held through reset release, it is treated as a new press: `pressionado` fires at edge 2+`N_DEBOUNCE` after the first edge with `reset`=0.
- **No overlap.** `pressionado[i]` and `soltou[i]` are never high in the same cycle, and never in consecutive cycles for the same bit. The minimum spacing is `N_DEBOUNCE` cycles.

## Test plan

- **Reset state.** Assert `reset` mid-cycle with `botoes_brutos`=8'hFF → all outputs 0 immediately. Release reset and hold 8'hFF → `botoes`=8'hFF, `pressionado`=8'hFF for one cycle, `multiplo`=1, all at edge 12.
- **Clean press and release.** Raise bit 3 and hold → `botoes`=8'h08 and `pressionado`=8'h08 at edge 12, `algum`=1. Drop bit 3 → `soltou`=8'h08 one cycle and `botoes`=8'h00 at edge 12 after the drop.
- **Bounce rejection.** Toggle bit 0 with high runs of 9 cycles separated by 1-cycle lows, then hold high → no `pressionado` during the bounce. A single pulse occurs exactly 12 edges after the start of the final stable high.
- **Simultaneous buttons.** Raise bits 1 and 6 in the same cycle → `pressionado`=8'h42 in one cycle and `multiplo` rises in that same cycle. Release bit 6 only → `soltou`=8'h40 and `multiplo` falls, `algum` stays 1.
- **Reset during confirmation.** Raise bit 5, then assert `reset` at edge 8 for 2 cycles while bit 5 stays high → no pulse before reset. `pressionado[5]` occurs 12 edges after reset release.
- **Short glitch.** Apply a 1-cycle high on bit 2 only → `botoes`, `pressionado`, `soltou` and the flags stay 0 throughout.
